hamming_secded_decoder: RTL and testbench

HAMMING_SECDED_DECODER -- requirements
Module: hamming_secded_decoder

---
 rtl/hamming_secded_decoder_pkg.sv | 40 ++++
 rtl/hamming_secded_decoder_syndrome.sv | 26 ++
 rtl/hamming_secded_decoder.sv | 152 +++++++++++++++
 tb/tb_hamming_secded_decoder.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_secded_decoder_pkg.sv
// Shared helpers for the SECDED decoder: check-bit count, codeword position to payload
// index map, and the error classification encoding.
package hamming_secded_decoder_pkg;

    typedef enum logic [2:0] {
        ClsClean,
        ClsOverall,
        ClsSingle,
        ClsRange,
        ClsDouble
    } err_class_e;

    // Smallest p with 2^p >= data_w + p + 1.
    function automatic int calc_p(input int data_w);
        int p;
        p = 1;
        for (int i = 0; i < 8; i++) begin
            if ((1 << p) < data_w + p + 1) begin
                p = p + 1;
            end
        end
        return p;
    endfunction

    // Payload index carried at Hamming position pos, or -1 for a check-bit position.
    function automatic int pos_to_idx(input int pos);
        int n_pow;
        n_pow = 0;
        if (pos <= 0 || (pos & (pos - 1)) == 0) begin
            return -1;
        end
        for (int j = 0; j < 31; j++) begin
            if ((1 << j) <= pos) begin
                n_pow = n_pow + 1;
            end
        end
        return pos - 1 - n_pow;
    endfunction

endpackage

// File: rtl/hamming_secded_decoder_syndrome.sv
// Combinational Hamming syndrome and overall parity of one SECDED codeword.
module hamming_syndrome
    import hamming_secded_decoder_pkg::*;
#(
    parameter int DATA_W = 12,
    localparam int P = calc_p(DATA_W),
    localparam int N = DATA_W + P + 1
) (
    input  logic [N-1:0] code,
    output logic [P-1:0] syndrome,
    output logic         overall
);

    always_comb begin
        syndrome = '0;
        for (int k = 1; k < N; k++) begin
            for (int j = 0; j < P; j++) begin
                if (((k >> j) & 1) == 1) begin
                    syndrome[j] = syndrome[j] ^ code[k-1];
                end
            end
        end
        overall = ^code;
    end

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage SECDED decoder: stage 1 registers syndrome and raw payload, stage 2 classifies,
// corrects and presents the result; saturating corrected/uncorrectable counters.
module hamming_secded_decoder
    import hamming_secded_decoder_pkg::*;
#(
    parameter int DATA_W  = 12,
    parameter int COUNT_W = 16,
    localparam int P = calc_p(DATA_W),
    localparam int N = DATA_W + P + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_code,
    input  logic               correct_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [P-1:0]       out_syndrome,
    output logic               out_corrected,
    output logic               out_uncorr,
    input  logic               cnt_clear,
    output logic [COUNT_W-1:0] corr_count,
    output logic [COUNT_W-1:0] uncorr_count
);

    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q;
    logic [P-1:0]      s1_syn_q;
    logic              s1_ovr_q;
    logic              s1_cen_q;

    logic [P-1:0]      syn_c;
    logic              ovr_c;
    logic [DATA_W-1:0] raw_c;
    logic              s1_adv;
    logic              s2_adv;
    logic              out_hs;

    err_class_e        cls;
    logic              is_check;
    logic              data_fix;
    logic              corr_d;
    logic              uncorr_d;
    logic [DATA_W-1:0] flip_c;

    hamming_syndrome #(
        .DATA_W(DATA_W)
    ) u_syndrome (
        .code    (in_code),
        .syndrome(syn_c),
        .overall (ovr_c)
    );

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign out_hs   = out_valid && out_ready;

    always_comb begin
        raw_c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            for (int pos = 1; pos < N; pos++) begin
                if (pos_to_idx(pos) == i) begin
                    raw_c[i] = in_code[pos-1];
                end
            end
        end
    end

    always_comb begin
        cls = ClsClean;
        if (s1_syn_q == '0) begin
            cls = s1_ovr_q ? ClsOverall : ClsClean;
        end else if (!s1_ovr_q) begin
            cls = ClsDouble;
        end else if (int'(s1_syn_q) > N - 1) begin
            cls = ClsRange;
        end else begin
            cls = ClsSingle;
        end
        // A single error on a check bit leaves the payload intact, so it always counts as fixed.
        is_check = $onehot(s1_syn_q);
        data_fix = (cls == ClsSingle) && !is_check && s1_cen_q;
        corr_d   = (cls == ClsOverall) || ((cls == ClsSingle) && (is_check || s1_cen_q));
        uncorr_d = (cls == ClsRange) || (cls == ClsDouble) ||
                   ((cls == ClsSingle) && !is_check && !s1_cen_q);
        flip_c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            for (int pos = 1; pos < N; pos++) begin
                if (pos_to_idx(pos) == i) begin
                    flip_c[i] = data_fix && (s1_syn_q == P'(pos));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_syn_q   <= '0;
            s1_ovr_q   <= 1'b0;
            s1_cen_q   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_data_q <= raw_c;
                s1_syn_q  <= syn_c;
                s1_ovr_q  <= ovr_c;
                s1_cen_q  <= correct_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_syndrome  <= '0;
            out_corrected <= 1'b0;
            out_uncorr    <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid_q;
            if (s1_valid_q) begin
                out_data      <= s1_data_q ^ flip_c;
                out_syndrome  <= s1_syn_q;
                out_corrected <= corr_d;
                out_uncorr    <= uncorr_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_count   <= '0;
            uncorr_count <= '0;
        end else if (cnt_clear) begin
            corr_count   <= '0;
            uncorr_count <= '0;
        end else if (out_hs) begin
            if (out_corrected && corr_count != '1) begin
                corr_count <= corr_count + COUNT_W'(1);
            end
            if (out_uncorr && uncorr_count != '1) begin
                uncorr_count <= uncorr_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Table-driven scoreboard bench for the SECDED decoder (DATA_W=12) with a second
// COUNT_W=2 instance sharing the stimulus to exercise counter saturation.
module tb_hamming_secded_decoder;

    typedef struct {
        logic [11:0] data;
        logic [17:0] flip;
        logic        cen;
        logic [11:0] exp_data;
        logic [4:0]  exp_syn;
        logic        exp_corr;
        logic        exp_uncorr;
    } vec_t;

    typedef struct {
        logic [11:0] d;
        logic [4:0]  s;
        logic        c;
        logic        u;
        logic        lat;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_code;
    logic        correct_en;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic [4:0]  out_syndrome;
    logic        out_corrected;
    logic        out_uncorr;
    logic        cnt_clear;
    logic [15:0] corr_count;
    logic [15:0] uncorr_count;

    logic        sat_in_ready;
    logic        sat_out_valid;
    logic [11:0] sat_out_data;
    logic [4:0]  sat_out_syndrome;
    logic        sat_out_corrected;
    logic        sat_out_uncorr;
    logic [1:0]  sat_corr_count;
    logic [1:0]  sat_uncorr_count;

    int   n_vec;
    int   n_fail;
    int   cyc;
    int   m_corr;
    int   m_unc;
    int   m_corr_s;
    int   m_unc_s;
    logic prev_stall;
    exp_t cur_exp;
    exp_t q[$];
    vec_t tbl[12];

    hamming_secded_decoder #(
        .DATA_W (12),
        .COUNT_W(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_code      (in_code),
        .correct_en   (correct_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_syndrome (out_syndrome),
        .out_corrected(out_corrected),
        .out_uncorr   (out_uncorr),
        .cnt_clear    (cnt_clear),
        .corr_count   (corr_count),
        .uncorr_count (uncorr_count)
    );

    hamming_secded_decoder #(
        .DATA_W (12),
        .COUNT_W(2)
    ) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (sat_in_ready),
        .in_code      (in_code),
        .correct_en   (correct_en),
        .out_valid    (sat_out_valid),
        .out_ready    (out_ready),
        .out_data     (sat_out_data),
        .out_syndrome (sat_out_syndrome),
        .out_corrected(sat_out_corrected),
        .out_uncorr   (sat_out_uncorr),
        .cnt_clear    (cnt_clear),
        .corr_count   (sat_corr_count),
        .uncorr_count (sat_uncorr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Independent SECDED encoder: payload at non-power-of-two positions, even parity.
    function automatic logic [17:0] encode(input logic [11:0] d);
        logic [17:0] c;
        logic        p;
        int          i;
        c = '0;
        i = 0;
        for (int pos = 1; pos <= 17; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[i];
                i++;
            end
        end
        for (int j = 0; j < 5; j++) begin
            p = 1'b0;
            for (int pos = 1; pos <= 17; pos++) begin
                if (((pos >> j) & 1) == 1 && (pos & (pos - 1)) != 0) begin
                    p = p ^ c[pos-1];
                end
            end
            c[(1 << j) - 1] = p;
        end
        c[17] = ^c[16:0];
        return c;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic popped;
        logic pc;
        logic pu;
        popped = 1'b0;
        pc     = 1'b0;
        pu     = 1'b0;
        cyc++;
        if (!rst_n) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_corr_count", 32'(corr_count), 32'd0);
            check("rst_uncorr_count", 32'(uncorr_count), 32'd0);
            q.delete();
            m_corr     = 0;
            m_unc      = 0;
            m_corr_s   = 0;
            m_unc_s    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !out_valid) begin
                fail("valid_dropped_while_stalled");
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    fail("stale_or_duplicate_word");
                end else begin
                    check("out_data", 32'(out_data), 32'(q[0].d));
                    check("out_syndrome", 32'(out_syndrome), 32'(q[0].s));
                    check("out_corrected", 32'(out_corrected), 32'(q[0].c));
                    check("out_uncorr", 32'(out_uncorr), 32'(q[0].u));
                    if (out_ready) begin
                        e = q.pop_front();
                        if (e.lat) begin
                            check("latency", 32'(cyc - e.cyc), 32'd2);
                        end
                        popped = 1'b1;
                        pc     = e.c;
                        pu     = e.u;
                    end
                end
            end
            check("corr_count", 32'(corr_count), 32'(m_corr));
            check("uncorr_count", 32'(uncorr_count), 32'(m_unc));
            check("sat_corr_count", 32'(sat_corr_count), 32'(m_corr_s));
            check("sat_uncorr_count", 32'(sat_uncorr_count), 32'(m_unc_s));
            if (cnt_clear) begin
                m_corr   = 0;
                m_unc    = 0;
                m_corr_s = 0;
                m_unc_s  = 0;
            end else if (popped) begin
                if (pc && m_corr < 65535) m_corr++;
                if (pu && m_unc < 65535) m_unc++;
                if (pc && m_corr_s < 3) m_corr_s++;
                if (pu && m_unc_s < 3) m_unc_s++;
            end
            if (in_valid && in_ready) begin
                e     = cur_exp;
                e.cyc = cyc;
                q.push_back(e);
            end
            prev_stall = out_valid && !out_ready;
        end
    end

    // Drive one word and hold it until the handshake edge has passed.
    task automatic send(input vec_t v, input logic lat);
        logic hs;
        int   budget;
        in_valid   = 1'b1;
        in_code    = encode(v.data) ^ v.flip;
        correct_en = v.cen;
        cur_exp    = '{d: v.exp_data, s: v.exp_syn, c: v.exp_corr, u: v.exp_uncorr,
                       lat: lat, cyc: 0};
        hs     = 1'b0;
        budget = 0;
        while (!hs && budget < 50) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!hs) fail("in_ready_timeout");
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((q.size() != 0 || out_valid) && budget < 100) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (budget >= 100) fail("drain_timeout");
    endtask

    initial begin
        #200000;
        fail("global_timeout");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int budget;
        n_vec      = 0;
        n_fail     = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_code    = '0;
        correct_en = 1'b0;
        out_ready  = 1'b1;
        cnt_clear  = 1'b0;

        tbl[0]  = '{12'hA5C, 18'h00000, 1'b1, 12'hA5C, 5'd0,  1'b0, 1'b0};
        tbl[1]  = '{12'hA5C, 18'h00040, 1'b1, 12'hA5C, 5'd7,  1'b1, 1'b0};
        tbl[2]  = '{12'hA5C, 18'h00014, 1'b1, 12'hA5F, 5'd6,  1'b0, 1'b1};
        tbl[3]  = '{12'hA5C, 18'h20000, 1'b1, 12'hA5C, 5'd0,  1'b1, 1'b0};
        tbl[4]  = '{12'hA5C, 18'h00040, 1'b0, 12'hA54, 5'd7,  1'b0, 1'b1};
        tbl[5]  = '{12'h000, 18'h00001, 1'b1, 12'h000, 5'd1,  1'b1, 1'b0};
        tbl[6]  = '{12'hFFF, 18'h10000, 1'b1, 12'hFFF, 5'd17, 1'b1, 1'b0};
        tbl[7]  = '{12'hFFF, 18'h10000, 1'b0, 12'h7FF, 5'd17, 1'b0, 1'b1};
        tbl[8]  = '{12'h123, 18'h20004, 1'b1, 12'h122, 5'd3,  1'b0, 1'b1};
        tbl[9]  = '{12'h5A5, 18'h08082, 1'b1, 12'h5A5, 5'd26, 1'b0, 1'b1};
        tbl[10] = '{12'h3C3, 18'h00800, 1'b1, 12'h3C3, 5'd12, 1'b1, 1'b0};
        tbl[11] = '{12'h800, 18'h00102, 1'b1, 12'h810, 5'd11, 1'b0, 1'b1};

        #3;
        check("init_out_valid", 32'(out_valid), 32'd0);
        check("init_in_ready", 32'(in_ready), 32'd1);
        check("init_out_data", 32'(out_data), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full table back-to-back with the sink always ready.
        for (int i = 0; i < 12; i++) send(tbl[i], 1'b1);
        idle();
        drain();
        check("table_corr_total", 32'(corr_count), 32'd5);
        check("table_uncorr_total", 32'(uncorr_count), 32'd6);
        check("table_sat_corr", 32'(sat_corr_count), 32'd3);

        // Fresh counters, one corrected word, then saturation on the narrow instance.
        cnt_clear = 1'b1;
        @(posedge clk);
        #1;
        cnt_clear = 1'b0;
        send(tbl[1], 1'b1);
        idle();
        drain();
        check("single_corr_count", 32'(corr_count), 32'd1);
        for (int i = 0; i < 4; i++) send(tbl[1], 1'b1);
        idle();
        drain();
        check("five_corr_count", 32'(corr_count), 32'd5);
        check("sat_corr_sticks", 32'(sat_corr_count), 32'd3);

        // Clear coinciding with a corrected output handshake.
        out_ready = 1'b0;
        send(tbl[1], 1'b0);
        idle();
        budget = 0;
        while (!out_valid && budget < 20) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!out_valid) fail("clear_test_no_output");
        cnt_clear = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        cnt_clear = 1'b0;
        check("clear_wins_corr", 32'(corr_count), 32'd0);
        check("clear_wins_sat", 32'(sat_corr_count), 32'd0);
        drain();

        // Eight words against a 1010... ready pattern.
        fork
            begin
                for (int i = 0; i < 8; i++) send(tbl[i], 1'b0);
                idle();
            end
            begin
                out_ready = 1'b1;
                repeat (30) begin
                    @(posedge clk);
                    #1;
                    out_ready = ~out_ready;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_corr_total", 32'(corr_count), 32'd4);

        // Reset with two words in flight.
        out_ready = 1'b0;
        send(tbl[1], 1'b0);
        send(tbl[2], 1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_corr", 32'(corr_count), 32'd0);
        check("midrst_uncorr", 32'(uncorr_count), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_data", 32'(out_data), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(tbl[3], 1'b1);
        idle();
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_corr", 32'(corr_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
